uart_transmitter: RTL and testbench
===================================

# uart_transmitter

Serial transmit stage of the UART path: accepts parallel bytes over a valid/ready handshake and shifts each out as one asynchronous frame on `tx_out`. A frame is start bit, 8 data bits LSB-first, optional parity bit and 1 or 2 stop bits. `tx_out` feeds the UART receiver's serial input directly. `tx_frame_start` marks the first cycle of every start bit and can drive the receiver's frame-start input in loopback configurations.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit; legal values are 1 to 65535.
- `PARITY_EN`, default 1: 1 inserts a parity bit after the data bits; 0 omits it.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd parity. Ignored when `PARITY_EN`=0.
- `STOP_BITS`, default 1: number of stop bits, 1 or 2.

- `clk`  in  1  Single clock; all logic on the rising edge.
- `rst_n`  in  1  Asynchronous, active-low reset.
- `tx_enable`  in  1  Gates acceptance of new bytes only. It never aborts a frame in flight.
- `tx_valid`  in  1  `tx_data` is valid.
- `tx_data`  in  8  Byte to send. Sampled only on the accept cycle.
- `tx_ready`  out  1  Block can accept a byte this cycle.
- `tx_out`  out  1  Serial line. Idle level is 1.
- `tx_busy`  out  1  A frame is in progress.
- `tx_frame_start`  out  1  One-cycle pulse on the first cycle of each start bit.
- `tx_done`  out  1  One-cycle pulse when a frame completes.

## Operation
- States:
  - IDLE: line high.
  - START: line 0.
  - DATA: `shift_reg[0]` driven on the line.
  - PARITY: line = parity bit.
  - STOP: line 1.
- Registers:
  - Baud counter, 16 bits, counts 0 to `CLKS_PER_BIT`-1.
  - Bit index, 3 bits.
  - Stop count.
  - 8-bit shift register.
  - Parity register.
- `tx_ready` = (state==IDLE) && `tx_enable` && `rst_n`. It is combinational from registered state.
- Accept occurs when `tx_valid` && `tx_ready` on a rising edge. On accept:
  - Load `tx_data` into the shift register.
  - Parity = XOR of `tx_data`, further XORed with `PARITY_ODD`.
  - Clear the baud counter and go to START.
- Every state except IDLE holds for exactly `CLKS_PER_BIT` cycles per bit. The baud counter wraps to 0 at the end of each bit.
- DATA: at the end of each bit, shift right and increment the bit index. After bit 7, go to PARITY if `PARITY_EN`=1, otherwise go to STOP.
- STOP: lasts `STOP_BITS` bit periods, then the block returns to IDLE.
- Frame length = (1+8+`PARITY_EN`+`STOP_BITS`) × `CLKS_PER_BIT` cycles.
- `tx_busy` = state != IDLE.
- `tx_data` changing after the accept cycle has no effect on the frame in flight.
- Dropping `tx_enable` mid-frame: the current frame completes normally and no new byte is accepted.
- Reset mid-frame: all state is cleared immediately and the frame is truncated. `tx_out` returns high asynchronously.

## Timing
- Reset values:
  - `tx_out`=1, `tx_busy`=0, `tx_ready`=0 while `rst_n`=0, `tx_frame_start`=0, `tx_done`=0.
  - State=IDLE; all counters and the shift register are 0.
- `tx_out` is driven from a register, so it is glitch-free.
- Latency: accept on edge N. Start bit and `tx_frame_start` appear in cycle N+1.
- `tx_done` is high in the first IDLE cycle after the last stop-bit cycle. `tx_ready` is high in that same cycle, provided `tx_enable`=1.
- Back-to-back frames: `tx_valid` held through the `tx_done` cycle is accepted in that cycle. The next start bit follows directly, adding exactly one extra idle-high cycle between frames.
- `tx_valid` while `tx_ready`=0 is ignored. There is no buffering, and the upstream block must hold the byte.
- `CLKS_PER_BIT`=1: one cycle per bit with no special casing. The frame is 11 cycles with default parity and stop settings.

## Test plan
- Reset then idle: hold `rst_n`=0 for 3 cycles, then release. Required: `tx_out`=1, `tx_ready`=1, `tx_busy`=0 for 20 cycles.
- Single byte, even parity (`CLKS_PER_BIT`=4, defaults): accept 0xA5.
  - Line sequence, each bit held 4 cycles: 0 | 1,0,1,0,0,1,0,1 | parity 0 | 1.
  - 44 cycles in total; `tx_done` in cycle 45 after the accept.
- Odd parity, two stop bits (`PARITY_ODD`=1, `STOP_BITS`=2, `CLKS_PER_BIT`=4): send 0x00. Required: parity bit = 1, stop high for 8 cycles, frame = 48 cycles.
- Back-to-back: hold `tx_valid` with 0x55 then 0x0F.
  - Required: two complete frames separated by exactly one idle cycle.
  - Exactly two `tx_frame_start` pulses and two `tx_done` pulses.
- Handshake and enable:
  - Drive `tx_valid` with 0xFF while busy. Required: ignored, no corruption of the current frame.
  - Deassert `tx_enable` mid-frame. Required: the frame finishes, `tx_ready` stays 0, no new frame starts.
- Reset mid-frame: assert `rst_n`=0 during DATA bit 3. Required: `tx_out`=1 immediately, all outputs at reset values. After release, 0x3C transmits correctly.
- Loopback: connect `tx_out` to the UART receiver with `CLKS_PER_BIT`=1. Send 0x81. Required: the receiver's output byte equals 0x81.

Source files
------------

// File: rtl/uart_transmitter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_transmitter
// Purpose  : Byte-in, asynchronous-frame-out serial transmitter (8 data bits,
//            optional parity, 1 or 2 stop bits) with a valid/ready input.
// Revision : 1.0 - initial release
// ============================================================================
module uart_transmitter #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_enable,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_out,
  output logic       tx_busy,
  output logic       tx_frame_start,
  output logic       tx_done
);

  localparam logic [15:0] c_baud_last = 16'(CLKS_PER_BIT - 1);
  localparam logic        c_stop_last = 1'(STOP_BITS - 1);
  localparam logic        c_par_en    = (PARITY_EN != 0);
  localparam logic        c_par_odd   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  state_t      r_state;
  logic [15:0] r_baud_cnt;
  logic [2:0]  r_bit_idx;
  logic        r_stop_cnt;
  logic [7:0]  r_shift;
  logic        r_parity;
  logic        r_tx_out;
  logic        r_frame_start;
  logic        r_done;

  logic w_bit_end;
  logic w_accept;

  assign w_bit_end      = (r_baud_cnt == c_baud_last);
  assign tx_ready       = (r_state == ST_IDLE) && tx_enable && rst_n;
  assign w_accept       = tx_valid && tx_ready;
  assign tx_busy        = (r_state != ST_IDLE);
  assign tx_out         = r_tx_out;
  assign tx_frame_start = r_frame_start;
  assign tx_done        = r_done;

  // The line level for the next bit is registered together with the state
  // change, so tx_out always switches exactly on the bit boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_baud_cnt    <= '0;
      r_bit_idx     <= '0;
      r_stop_cnt    <= 1'b0;
      r_shift       <= '0;
      r_parity      <= 1'b0;
      r_tx_out      <= 1'b1;
      r_frame_start <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_frame_start <= 1'b0;
      r_done        <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_tx_out <= 1'b1;
          if (w_accept) begin
            r_shift       <= tx_data;
            r_parity      <= (^tx_data) ^ c_par_odd;
            r_baud_cnt    <= '0;
            r_state       <= ST_START;
            r_tx_out      <= 1'b0;
            r_frame_start <= 1'b1;
          end
        end
        ST_START: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_state    <= ST_DATA;
            r_tx_out   <= r_shift[0];
          end else begin
            r_baud_cnt <= r_baud_cnt + 16'd1;
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            r_shift    <= {1'b0, r_shift[7:1]};
            r_bit_idx  <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) begin
              r_stop_cnt <= 1'b0;
              r_state    <= c_par_en ? ST_PARITY : ST_STOP;
              r_tx_out   <= c_par_en ? r_parity : 1'b1;
            end else begin
              r_tx_out <= r_shift[1];
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 16'd1;
          end
        end
        ST_PARITY: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            r_stop_cnt <= 1'b0;
            r_state    <= ST_STOP;
            r_tx_out   <= 1'b1;
          end else begin
            r_baud_cnt <= r_baud_cnt + 16'd1;
          end
        end
        ST_STOP: begin
          r_tx_out <= 1'b1;
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            if (r_stop_cnt == c_stop_last) begin
              r_stop_cnt <= 1'b0;
              r_state    <= ST_IDLE;
              r_done     <= 1'b1;
            end else begin
              r_stop_cnt <= r_stop_cnt + 1'b1;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 16'd1;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_tx_out <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_transmitter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_transmitter
// Purpose  : Three transmitter configurations against a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_transmitter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid [3];
  logic [7:0] data  [3];
  logic       en    [3];
  logic       w_rdy [3];
  logic       w_out [3];
  logic       w_busy[3];
  logic       w_fs  [3];
  logic       w_done[3];

  int checks = 0;
  int fails  = 0;

  // Instance configurations: 0 = CPB 4 even/1 stop, 1 = CPB 4 odd/2 stop, 2 = CPB 1
  int cpb   [3] = '{4, 4, 1};
  int pen   [3] = '{1, 1, 1};
  int podd  [3] = '{0, 1, 0};
  int nstop [3] = '{1, 2, 1};

  always #5 clk = ~clk;

  uart_transmitter #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_a (
    .clk(clk), .rst_n(rst_n), .tx_enable(en[0]), .tx_valid(valid[0]), .tx_data(data[0]),
    .tx_ready(w_rdy[0]), .tx_out(w_out[0]), .tx_busy(w_busy[0]),
    .tx_frame_start(w_fs[0]), .tx_done(w_done[0]));

  uart_transmitter #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_b (
    .clk(clk), .rst_n(rst_n), .tx_enable(en[1]), .tx_valid(valid[1]), .tx_data(data[1]),
    .tx_ready(w_rdy[1]), .tx_out(w_out[1]), .tx_busy(w_busy[1]),
    .tx_frame_start(w_fs[1]), .tx_done(w_done[1]));

  uart_transmitter #(.CLKS_PER_BIT(1), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_c (
    .clk(clk), .rst_n(rst_n), .tx_enable(en[2]), .tx_valid(valid[2]), .tx_data(data[2]),
    .tx_ready(w_rdy[2]), .tx_out(w_out[2]), .tx_busy(w_busy[2]),
    .tx_frame_start(w_fs[2]), .tx_done(w_done[2]));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Frame bits in transmit order, bit 0 first.
  function automatic logic [11:0] frame(input logic [7:0] d, input int i);
    logic p;
    p = (pen[i] != 0) ? ((^d) ^ (podd[i] != 0)) : 1'b1;
    return {2'b11, p, d, 1'b0};
  endfunction

  function automatic logic [63:0] expand(input logic [11:0] bits, input int len, input int c);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < len; k++) r[k] = bits[k / c];
    return r;
  endfunction

  // Model: t = cycles since accept (1 = first start-bit cycle), 0 = idle.
  int          t  [3] = '{0, 0, 0};
  logic [11:0] fb [3];
  int          m_len;
  logic        e_out, e_busy, e_fs, e_done, e_rdy;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      m_len = (9 + pen[i] + nstop[i]) * cpb[i];
      if (!rst_n) begin
        t[i] = 0;
        e_out = 1'b1; e_busy = 1'b0; e_fs = 1'b0; e_done = 1'b0; e_rdy = 1'b0;
      end else begin
        e_busy = (t[i] >= 1) && (t[i] <= m_len);
        e_out  = e_busy ? fb[i][(t[i] - 1) / cpb[i]] : 1'b1;
        e_fs   = (t[i] == 1);
        e_done = (t[i] == m_len + 1);
        e_rdy  = !e_busy && en[i];
      end
      chk($sformatf("m%0d_out", i),   w_out[i],  e_out);
      chk($sformatf("m%0d_busy", i),  w_busy[i], e_busy);
      chk($sformatf("m%0d_fs", i),    w_fs[i],   e_fs);
      chk($sformatf("m%0d_done", i),  w_done[i], e_done);
      chk($sformatf("m%0d_ready", i), w_rdy[i],  e_rdy);
      if (rst_n) begin
        if (valid[i] && e_rdy) begin
          fb[i] = frame(data[i], i);
          t[i]  = 1;
        end else if (t[i] == m_len + 1) begin
          t[i] = 0;
        end else if (t[i] != 0) begin
          t[i]++;
        end
      end
    end
  end

  // Presents a byte and returns one time unit after the accepting edge.
  task automatic send(input int i, input logic [7:0] b);
    int ok;
    @(posedge clk); #1;
    valid[i] = 1'b1;
    data[i]  = b;
    ok = 0;
    for (int k = 0; k < 500 && ok == 0; k++) begin
      @(negedge clk);
      if (w_rdy[i]) ok = 1;
    end
    chk($sformatf("send%0d_accept", i), ok, 1);
    @(posedge clk); #1;
    valid[i] = 1'b0;
    data[i]  = 8'($urandom);
  endtask

  task automatic capture(input int i, input int len, output logic [63:0] line, output int nrdy);
    line = '0;
    nrdy = 0;
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      line[k] = w_out[i];
      if (w_rdy[i]) nrdy++;
    end
  endtask

  initial begin
    #2_000_000;
    fails++;
    $display("FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    logic [63:0] line;
    logic [7:0]  rxb;
    logic        rxp, rxs, acc_now;
    int nrdy, nfs, ndone, nacc, first_done, second_fs, ok;

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      valid[i] = 1'b0; data[i] = 8'h00; en[i] = 1'b1;
    end
    repeat (3) begin
      @(negedge clk);
      chk("rst_out", w_out[0], 1);
      chk("rst_ready", w_rdy[0], 0);
      chk("rst_busy", w_busy[0], 0);
      chk("rst_done", w_done[0], 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("idle_out", w_out[0], 1);
      chk("idle_ready", w_rdy[0], 1);
      chk("idle_busy", w_busy[0], 0);
    end

    // 0xA5, even parity, 4 clocks per bit
    send(0, 8'hA5);
    capture(0, 44, line, nrdy);
    chk("a5_line", line, expand({1'b1, 1'b0, 8'hA5, 1'b0}, 44, 4));
    chk("a5_ready_while_busy", nrdy, 0);
    @(negedge clk);
    chk("a5_done_c45", w_done[0], 1);

    // 0x00, odd parity, two stop bits
    send(1, 8'h00);
    capture(1, 48, line, nrdy);
    chk("odd_line", line, expand({2'b11, 1'b1, 8'h00, 1'b0}, 48, 4));
    chk("odd_parity_bit", line[36], 1);
    @(negedge clk);
    chk("odd_done_c49", w_done[1], 1);

    // Back-to-back 0x55 then 0x0F
    @(posedge clk); #1;
    valid[0] = 1'b1; data[0] = 8'h55;
    ok = 0;
    for (int k = 0; k < 200 && ok == 0; k++) begin
      @(negedge clk);
      if (w_rdy[0]) ok = 1;
    end
    chk("b2b_first_accept", ok, 1);
    @(posedge clk); #1;
    data[0] = 8'h0F;
    nacc = 1; nfs = 0; ndone = 0; first_done = -1; second_fs = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (w_fs[0]) begin nfs++; if (nfs == 2) second_fs = k; end
      if (w_done[0]) begin ndone++; if (ndone == 1) first_done = k; end
      acc_now = w_rdy[0] && valid[0];
      @(posedge clk); #1;
      if (acc_now) begin nacc++; if (nacc == 2) valid[0] = 1'b0; end
    end
    valid[0] = 1'b0;
    chk("b2b_fs_count", nfs, 2);
    chk("b2b_done_count", ndone, 2);
    chk("b2b_first_done", first_done, 44);
    chk("b2b_gap", second_fs, first_done + 1);

    // 0xFF offered while busy must be ignored
    send(0, 8'h5A);
    valid[0] = 1'b1; data[0] = 8'hFF;
    capture(0, 44, line, nrdy);
    @(posedge clk); #1;
    valid[0] = 1'b0;
    chk("busy_ignore_line", line, expand({1'b1, 1'b0, 8'h5A, 1'b0}, 44, 4));
    chk("busy_ignore_ready", nrdy, 0);

    // Enable dropped mid-frame
    send(0, 8'h96);
    repeat (10) @(posedge clk);
    #1;
    en[0] = 1'b0; valid[0] = 1'b1; data[0] = 8'hFF;
    nfs = 0; ndone = 0; nrdy = 0;
    for (int k = 0; k < 70; k++) begin
      @(negedge clk);
      if (w_fs[0]) nfs++;
      if (w_done[0]) ndone++;
      if (w_rdy[0]) nrdy++;
    end
    chk("en_drop_no_start", nfs, 0);
    chk("en_drop_done", ndone, 1);
    chk("en_drop_ready", nrdy, 0);
    chk("en_drop_idle", w_busy[0], 0);
    @(posedge clk); #1;
    valid[0] = 1'b0; en[0] = 1'b1;

    // Reset during data bit 3
    send(0, 8'h00);
    repeat (17) @(posedge clk);
    #1;
    chk("pre_reset_line", w_out[0], 0);
    chk("pre_reset_busy", w_busy[0], 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_out", w_out[0], 1);
    chk("async_rst_busy", w_busy[0], 0);
    chk("async_rst_ready", w_rdy[0], 0);
    chk("async_rst_fs", w_fs[0], 0);
    chk("async_rst_done", w_done[0], 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(0, 8'h3C);
    capture(0, 44, line, nrdy);
    chk("post_rst_line", line, expand({1'b1, 1'b0, 8'h3C, 1'b0}, 44, 4));
    @(negedge clk);
    chk("post_rst_done", w_done[0], 1);

    // Loopback decode at 1 clock per bit
    send(2, 8'h81);
    ok = 0;
    for (int k = 0; k < 20 && ok == 0; k++) begin
      @(negedge clk);
      if (w_out[2] == 1'b0) ok = 1;
    end
    chk("lb_start_seen", ok, 1);
    rxb = '0;
    for (int b = 0; b < 8; b++) begin
      @(negedge clk);
      rxb[b] = w_out[2];
    end
    @(negedge clk); rxp = w_out[2];
    @(negedge clk); rxs = w_out[2];
    chk("lb_byte", rxb, 8'h81);
    chk("lb_parity", rxp, 0);
    chk("lb_stop", rxs, 1);

    // Randomized traffic on all configurations
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        valid[i] = ($urandom_range(0, 3) != 0);
        data[i]  = 8'($urandom);
        en[i]    = ($urandom_range(0, 15) != 0);
      end
    end
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      valid[i] = 1'b0; en[i] = 1'b1;
    end
    repeat (150) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
